// File: rtl/spi_pkg.sv
// Shared constants for the SPI front end: channel indices and the
// default debounce configuration of the input conditioner.
package spi_pkg;

    localparam int CH_CS   = 0;
    localparam int CH_SCLK = 1;
    localparam int CH_MOSI = 2;

    localparam int DEF_WIDTH         = 3;
    localparam int DEF_COUNTER_WIDTH = 3;
    localparam int DEF_WAIT_TIME     = 3;

    // cs idles high, sclk and mosi idle low
    localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = 3'b001;

endpackage

// File: rtl/spi_input_conditioner_bit.sv
// One conditioner channel: two-flop synchronizer, stability counter and
// registered rising/falling strobes that coincide with the level change.
module input_conditioner_bit
    import spi_pkg::*;
#(
    parameter int   COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int   WAIT_TIME     = DEF_WAIT_TIME,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    output logic conditioned,
    output logic positive_edge,
    output logic negative_edge
);

    localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    logic                     r_sync0;
    logic                     r_sync1;
    logic                     r_level;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_pos;
    logic                     r_neg;

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values; the synchronizer is reset to the idle level too, so
    // reset release never looks like an input change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= RESET_VAL;
            r_sync1 <= RESET_VAL;
            r_level <= RESET_VAL;
            r_count <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_sync0 <= noisy;
            r_sync1 <= r_sync0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            if (r_sync1 == r_level) begin
                r_count <= '0;
            end else if (r_count == WAIT_CNT) begin
                // Disagreement held for WAIT_TIME+1 cycles: accept it
                r_level <= r_sync1;
                r_count <= '0;
                r_pos   <= r_sync1;
                r_neg   <= ~r_sync1;
            end else begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign conditioned   = r_level;
    assign positive_edge = r_pos;
    assign negative_edge = r_neg;

endmodule

// File: rtl/spi_input_conditioner.sv
// Conditions the raw SPI pins (cs, sclk, mosi) into clean levels and edge
// strobes for the slave FSM; one independent channel per pin.
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter int               COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int               WAIT_TIME     = DEF_WAIT_TIME,
    parameter logic [WIDTH-1:0] RESET_VAL     = DEF_RESET_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] noisy,
    output logic [WIDTH-1:0] conditioned,
    output logic [WIDTH-1:0] positive_edge,
    output logic [WIDTH-1:0] negative_edge
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        input_conditioner_bit #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .WAIT_TIME     (WAIT_TIME),
            .RESET_VAL     (RESET_VAL[i])
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .noisy         (noisy[i]),
            .conditioned   (conditioned[i]),
            .positive_edge (positive_edge[i]),
            .negative_edge (negative_edge[i])
        );
    end

endmodule
